// File: rtl/decmpp_pkg.sv
// Shared constants and arithmetic helpers for the midpoint-prediction reconstruction stage.
package decmpp_pkg;

    localparam int NSAMP = 16;

    // Samples feeding the next block's mean: (row0,col0), (row0,col1), (row1,col0), (row1,col1).
    localparam logic [3:0][3:0] MEAN_TAP = {4'd9, 4'd8, 4'd1, 4'd0};

    // Callers sign- or zero-extend their operands into the 32-bit signed container.
    function automatic logic signed [31:0] clip3(input logic signed [31:0] hi,
                                                 input logic signed [31:0] lo,
                                                 input logic signed [31:0] x);
        if (x < lo)
            return lo;
        else if (x > hi)
            return hi;
        else
            return x;
    endfunction

    function automatic logic [31:0] mpp_bias(input logic [3:0] step);
        return (step == 4'd0) ? 32'd0 : (32'd1 << (step - 4'd1));
    endfunction

    function automatic logic [31:0] mpp_maxclip(input logic [3:0] bd, input logic [3:0] step);
        logic [31:0] max_val;
        logic [31:0] lim;
        max_val = (32'd1 << bd) - 32'd1;
        lim     = (32'd1 << (bd - 4'd1)) + (mpp_bias(step) << 1);
        return (lim < max_val) ? lim : max_val;
    endfunction

endpackage

// File: rtl/decmpp_rec_lane.sv
// One sample of reconstruction: signed dequantisation shift, add predictor, clip to [0, maxVal].
module decmpp_rec_lane
    import decmpp_pkg::*;
#(
    parameter int RES_W  = 12,
    parameter int MAX_BD = 12
) (
    input  logic [RES_W-1:0]  res_i,
    input  logic [3:0]        step_i,
    input  logic [MAX_BD-1:0] mp_i,
    input  logic [MAX_BD-1:0] max_val_i,
    output logic [MAX_BD-1:0] rec_o
);

    // Wide enough that a full-scale residual shifted by the largest step cannot overflow.
    localparam int DW = RES_W + MAX_BD + 2;

    logic signed [DW-1:0]     deq;
    logic signed [DW-1:0]     sum;
    logic signed [31:0]       clipped;
    logic [31-MAX_BD:0]       unused_hi;

    always_comb begin
        deq       = $signed({{(DW-RES_W){res_i[RES_W-1]}}, res_i}) <<< step_i;
        sum       = deq + $signed({{(DW-MAX_BD){1'b0}}, mp_i});
        clipped   = clip3($signed({{(32-MAX_BD){1'b0}}, max_val_i}), 32'sd0, 32'(sum));
        rec_o     = clipped[MAX_BD-1:0];
        unused_hi = clipped[31:MAX_BD];
    end

endmodule

// File: rtl/decmpp_rec_mc.sv
// Multi-component MPP reconstruction: S1 holds the beat and its predictor, S2 holds the clipped samples.
module decmpp_rec_mc
    import decmpp_pkg::*;
#(
    parameter int MAX_BD   = 12,
    parameter int RES_W    = 12,
    parameter int NUM_COMP = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [1:0]                in_comp,
    input  logic                      in_first,
    input  logic [3:0]                in_step,
    input  logic [3:0]                in_bd,
    input  logic [NSAMP*RES_W-1:0]    in_res,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [1:0]                out_comp,
    output logic [NSAMP*MAX_BD-1:0]   out_rec
);

    logic                      s1_vld_q;
    logic [1:0]                s1_comp_q;
    logic [3:0]                s1_step_q;
    logic [MAX_BD-1:0]         s1_max_val_q;
    logic [MAX_BD-1:0]         s1_mp_q;
    logic [NSAMP*RES_W-1:0]    s1_res_q;

    logic                      out_vld_q;
    logic [1:0]                out_comp_q;
    logic [NSAMP*MAX_BD-1:0]   out_rec_q;

    logic [MAX_BD-1:0]         mean_q [NUM_COMP];
    logic [NUM_COMP-1:0]       hist_vld_q;

    logic                      s2_load;
    logic                      s1_free;
    logic                      s1_move;
    logic                      accept;

    logic [31:0]               middle;
    logic [31:0]               max_val_full;
    logic [31:0]               bias;
    logic [31:0]               max_clip;
    logic [MAX_BD-1:0]         mean_sel;
    logic signed [31:0]        mp_full;
    logic [MAX_BD-1:0]         mp_d;
    logic [MAX_BD-1:0]         max_val_d;

    logic [NSAMP*MAX_BD-1:0]   rec_w;
    logic [MAX_BD+1:0]         tap_sum;
    logic [MAX_BD-1:0]         mean_d;
    logic [2*(32-MAX_BD)+1:0]  unused_bits;

    // A component's mean is only valid once its previous block has left S1, hence the same-comp stall.
    always_comb begin
        s2_load = !out_vld_q || out_rdy;
        s1_free = !s1_vld_q || s2_load;
        s1_move = s1_vld_q && s2_load;
        in_rdy  = s1_free && !(s1_vld_q && (s1_comp_q == in_comp));
        accept  = in_vld && in_rdy;
    end

    always_comb begin
        middle       = 32'd1 << (in_bd - 4'd1);
        max_val_full = (32'd1 << in_bd) - 32'd1;
        bias         = mpp_bias(in_step);
        max_clip     = mpp_maxclip(in_bd, in_step);
        mean_sel     = middle[MAX_BD-1:0];
        if (!in_first) begin
            for (int c = 0; c < NUM_COMP; c++) begin
                if (in_comp == 2'(c) && hist_vld_q[c])
                    mean_sel = mean_q[c];
            end
        end
        mp_full   = clip3($signed(max_clip), $signed(middle),
                          $signed({{(32-MAX_BD){1'b0}}, mean_sel} + (bias << 1)));
        mp_d      = mp_full[MAX_BD-1:0];
        max_val_d = max_val_full[MAX_BD-1:0];
    end

    for (genvar gi = 0; gi < NSAMP; gi++) begin : g_lane
        decmpp_rec_lane #(
            .RES_W  (RES_W),
            .MAX_BD (MAX_BD)
        ) u_lane (
            .res_i     (s1_res_q[gi*RES_W +: RES_W]),
            .step_i    (s1_step_q),
            .mp_i      (s1_mp_q),
            .max_val_i (s1_max_val_q),
            .rec_o     (rec_w[gi*MAX_BD +: MAX_BD])
        );
    end

    always_comb begin
        tap_sum = '0;
        for (int k = 0; k < 4; k++)
            tap_sum = tap_sum + {2'b00, rec_w[int'(MEAN_TAP[k])*MAX_BD +: MAX_BD]};
        mean_d      = tap_sum[MAX_BD+1:2];
        unused_bits = {mp_full[31:MAX_BD], max_val_full[31:MAX_BD], tap_sum[1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q     <= 1'b0;
            s1_comp_q    <= '0;
            s1_step_q    <= '0;
            s1_max_val_q <= '0;
            s1_mp_q      <= '0;
            s1_res_q     <= '0;
            out_vld_q    <= 1'b0;
            out_comp_q   <= '0;
            out_rec_q    <= '0;
            hist_vld_q   <= '0;
            for (int c = 0; c < NUM_COMP; c++)
                mean_q[c] <= '0;
        end else begin
            if (s2_load) begin
                out_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    out_comp_q <= s1_comp_q;
                    out_rec_q  <= rec_w;
                end
            end
            if (s1_free) begin
                s1_vld_q <= accept;
                if (accept) begin
                    s1_comp_q    <= in_comp;
                    s1_step_q    <= in_step;
                    s1_max_val_q <= max_val_d;
                    s1_mp_q      <= mp_d;
                    s1_res_q     <= in_res;
                end
            end
            for (int c = 0; c < NUM_COMP; c++) begin
                if (s1_move && s1_comp_q == 2'(c)) begin
                    mean_q[c]     <= mean_d;
                    hist_vld_q[c] <= 1'b1;
                end
            end
        end
    end

    assign out_vld  = out_vld_q;
    assign out_comp = out_comp_q;
    assign out_rec  = out_rec_q;

endmodule

// File: tb/tb_decmpp_rec_mc.sv
// Scoreboard bench: a block-level reference model predicts each output, a negedge monitor checks it.
module tb_decmpp_rec_mc;

    localparam int MAX_BD = 12;
    localparam int RES_W  = 12;
    localparam int NS     = 16;
    localparam int RW     = NS * RES_W;
    localparam int OW     = NS * MAX_BD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [1:0]    in_comp = 2'd0;
    logic          in_first = 1'b0;
    logic [3:0]    in_step = 4'd0;
    logic [3:0]    in_bd = 4'd8;
    logic [RW-1:0] in_res = '0;
    logic          out_vld;
    logic          out_rdy = 1'b1;
    logic [1:0]    out_comp;
    logic [OW-1:0] out_rec;

    always #5 clk = ~clk;

    decmpp_rec_mc #(
        .MAX_BD   (MAX_BD),
        .RES_W    (RES_W),
        .NUM_COMP (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_comp  (in_comp),
        .in_first (in_first),
        .in_step  (in_step),
        .in_bd    (in_bd),
        .in_res   (in_res),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_comp (out_comp),
        .out_rec  (out_rec)
    );

    typedef struct {
        logic [1:0]    comp;
        logic [OW-1:0] rec;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   m_mean [4];
    bit   m_hist [4];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   out_prev_cyc = 0;
    int   out_last_cyc = 0;
    bit   rand_bp = 1'b0;

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: process blocks in acceptance order, each component keeping its own last-block mean.
    task automatic model_push(input logic [1:0] c, input logic f, input logic [3:0] st,
                              input logic [3:0] bd, input logic [RW-1:0] res);
        int   maxv, mid, bias, mean, maxclip, mp, v;
        int   r [NS];
        exp_t e;
        maxv    = (1 << bd) - 1;
        mid     = 1 << (bd - 1);
        bias    = (st == 0) ? 0 : (1 << (st - 1));
        mean    = (f || !m_hist[c]) ? mid : m_mean[c];
        maxclip = (mid + 2 * bias < maxv) ? mid + 2 * bias : maxv;
        mp      = mean + 2 * bias;
        if (mp > maxclip) mp = maxclip;
        if (mp < mid) mp = mid;
        e.comp = c;
        e.rec  = '0;
        for (int i = 0; i < NS; i++) begin
            v = int'($signed(res[i*RES_W +: RES_W])) * (1 << st) + mp;
            if (v < 0) v = 0;
            if (v > maxv) v = maxv;
            r[i] = v;
            e.rec[i*MAX_BD +: MAX_BD] = v[MAX_BD-1:0];
        end
        m_mean[c] = (r[0] + r[1] + r[8] + r[9]) / 4;
        m_hist[c] = 1'b1;
        exp_q.push_back(e);
    endtask

    bit            hold_pend = 1'b0;
    logic [1:0]    hold_comp;
    logic [OW-1:0] hold_rec;
    bit            prev_acc = 1'b0;
    logic [1:0]    prev_comp;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            hold_pend = 1'b0;
            prev_acc  = 1'b0;
            for (int c = 0; c < 4; c++) begin
                m_mean[c] = 0;
                m_hist[c] = 1'b0;
            end
        end else begin
            if (hold_pend) begin
                chk("hold_vld", out_vld, 1'b1);
                chk("hold_comp", out_comp, hold_comp);
                chk("hold_rec", out_rec, hold_rec);
                hold_pend = 1'b0;
            end
            if (out_vld && !out_rdy) begin
                hold_pend = 1'b1;
                hold_comp = out_comp;
                hold_rec  = out_rec;
            end
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_vld, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_comp", out_comp, mon_e.comp);
                    chk("out_rec", out_rec, mon_e.rec);
                    $display("cyc %0d out comp=%0d rec0=%0d rec1=%0d", cyc, out_comp,
                             out_rec[MAX_BD-1:0], out_rec[2*MAX_BD-1:MAX_BD]);
                end
                out_prev_cyc = out_last_cyc;
                out_last_cyc = cyc;
            end
            if (prev_acc && in_vld && in_comp == prev_comp)
                chk("hazard_rdy", in_rdy, 1'b0);
            prev_acc  = in_vld && in_rdy;
            prev_comp = in_comp;
            if (in_vld && in_rdy) begin
                acc_cnt++;
                model_push(in_comp, in_first, in_step, in_bd, in_res);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [OW-1:0] fill(input int v);
        logic [OW-1:0] x;
        for (int i = 0; i < NS; i++) x[i*MAX_BD +: MAX_BD] = v[MAX_BD-1:0];
        return x;
    endfunction

    function automatic logic [RW-1:0] res_fill(input int v);
        logic [RW-1:0] x;
        for (int i = 0; i < NS; i++) x[i*RES_W +: RES_W] = v[RES_W-1:0];
        return x;
    endfunction

    function automatic logic [RW-1:0] rand_res(input bit big);
        logic [RW-1:0] x;
        int v;
        for (int i = 0; i < NS; i++) begin
            v = big ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 127)) - 64;
            x[i*RES_W +: RES_W] = v[RES_W-1:0];
        end
        return x;
    endfunction

    function automatic logic [MAX_BD-1:0] samp(input int i);
        return out_rec[i*MAX_BD +: MAX_BD];
    endfunction

    task automatic send(input logic [1:0] c, input logic f, input logic [3:0] st,
                        input logic [3:0] bd, input logic [RW-1:0] res, output int waits);
        bit acc;
        in_vld = 1'b1; in_comp = c; in_first = f; in_step = st; in_bd = bd; in_res = res;
        waits = 0;
        acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_rdy;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        if (!acc) chk("send_timeout", acc, 1'b1);
        in_vld = 1'b0;
    endtask

    task automatic wait_out(input int maxc, input logic [1:0] c, output int lat);
        lat = -1;
        for (int n = 1; n <= maxc; n++) begin
            @(negedge clk);
            if (out_vld && out_comp == c) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) chk("wait_out_timeout", lat, 0);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waits, lat, tot, a0;
        logic [RW-1:0] r;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_vld", out_vld, 1'b0);
        chk("reset_out_comp", out_comp, 2'd0);
        chk("reset_out_rec", out_rec, '0);
        chk("reset_in_rdy", in_rdy, 1'b1);
        sync();

        // Base case and latency
        send(2'd0, 1'b1, 4'd2, 4'd8, res_fill(0), waits);
        wait_out(10, 2'd0, lat);
        chk("base_latency", lat, 2);
        chk("base_rec", out_rec, fill(132));
        sync();

        // Clipping at both ends
        r = res_fill(0);
        r[0 +: RES_W] = 12'd1;
        r[RES_W +: RES_W] = 12'hFD8;
        r[2*RES_W +: RES_W] = 12'd40;
        send(2'd2, 1'b1, 4'd2, 4'd8, r, waits);
        wait_out(10, 2'd2, lat);
        chk("clip_s0", samp(0), 136);
        chk("clip_s1", samp(1), 0);
        chk("clip_s2", samp(2), 255);
        sync();

        // History use, then a first block ignoring it
        send(2'd1, 1'b1, 4'd2, 4'd8, res_fill(0), waits);
        r = res_fill(0);
        r[0 +: RES_W] = 12'd5;
        r[RES_W +: RES_W] = 12'hF38;
        r[2*RES_W +: RES_W] = 12'd127;
        send(2'd0, 1'b0, 4'd0, 4'd8, r, waits);
        wait_out(10, 2'd0, lat);
        chk("hist_s0", samp(0), 133);
        chk("hist_s1", samp(1), 0);
        chk("hist_s2", samp(2), 255);
        chk("hist_s3", samp(3), 128);
        sync();
        send(2'd0, 1'b1, 4'd2, 4'd8, res_fill(0), waits);
        wait_out(10, 2'd0, lat);
        chk("refirst_s0", samp(0), 132);
        sync();

        // Same-component hazard and interleaved components
        send(2'd0, 1'b1, 4'd2, 4'd8, rand_res(1'b0), waits);
        send(2'd0, 1'b0, 4'd3, 4'd10, rand_res(1'b0), waits);
        chk("hazard_waits", waits, 1);
        repeat (4) sync();
        chk("hazard_spacing", out_last_cyc - out_prev_cyc, 2);
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            send(2'((i == 3) ? 0 : i), 1'b0, 4'd1, 4'd9, rand_res(1'b0), waits);
            tot += waits;
        end
        chk("interleave_waits", tot, 0);
        repeat (6) sync();

        // Backpressure with three beats offered
        out_rdy = 1'b0;
        a0 = acc_cnt;
        fork
            begin
                int w;
                send(2'd0, 1'b0, 4'd2, 4'd11, rand_res(1'b0), w);
                send(2'd1, 1'b0, 4'd2, 4'd11, rand_res(1'b0), w);
                send(2'd2, 1'b0, 4'd2, 4'd11, rand_res(1'b0), w);
            end
            begin
                repeat (5) @(negedge clk);
                chk("bp_inflight", acc_cnt - a0, 2);
                chk("bp_out_vld", out_vld, 1'b1);
                @(posedge clk);
                #1 out_rdy = 1'b1;
            end
        join
        repeat (6) sync();

        // Bit depth 12
        send(2'd1, 1'b1, 4'd4, 4'd12, res_fill(100), waits);
        wait_out(10, 2'd1, lat);
        chk("bd12_rec", out_rec, fill(3664));
        sync();

        // Reset with blocks in flight; a low comp1 history must not survive
        send(2'd1, 1'b1, 4'd4, 4'd12, res_fill(-100), waits);
        send(2'd0, 1'b1, 4'd2, 4'd8, rand_res(1'b0), waits);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_vld", out_vld, 1'b0);
        chk("rst_in_rdy", in_rdy, 1'b1);
        sync();
        send(2'd1, 1'b0, 4'd4, 4'd12, res_fill(0), waits);
        wait_out(10, 2'd1, lat);
        chk("post_rst_hist", samp(0), 2064);
        sync();

        // Randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] st, bd;
            bd = 4'($urandom_range(8, 12));
            st = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 12));
            send(2'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0), st, bd,
                 rand_res($urandom_range(0, 3) == 0), waits);
            if ($urandom_range(0, 5) == 0) sync();
        end
        rand_bp = 1'b0;
        repeat (2) @(posedge clk);
        #2 out_rdy = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
        repeat (5) @(posedge clk);
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
